pep9_control_sequencer: RTL and testbench

PEP9_CONTROL_SEQUENCER -- requirements
Module: pep9_control_sequencer

---
 rtl/pep9_ctrl_pkg.sv | 50 +++++
 rtl/pep9_control_sequencer_if.sv | 9 +
 rtl/pep9_is_decode.sv | 37 +++
 rtl/pep9_control_sequencer.sv | 152 +++++++++++++++
 tb/tb_pep9_control_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pep9_ctrl_pkg.sv
// Shared types and constants for the Pep9 control sequencer: FSM states, ALU codes,
// opcode bounds and the decode-entry record. The TRAP state exists only with PEP9_TRAP_EN.
package pep9_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH_IS,
    DECODE,
    FETCH_OP_HI,
    FETCH_OP_LO,
    EXEC,
    WB,
`ifdef PEP9_TRAP_EN
    HALT,
    TRAP
`else
    HALT
`endif
  } state_t;

  localparam logic [3:0] ALU_A    = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_NOT  = 4'd10;
  localparam logic [3:0] ALU_ASL  = 4'd11;
  localparam logic [3:0] ALU_ASR  = 4'd13;
  localparam logic [3:0] ALU_NZVC = 4'd15;

  localparam logic [7:0] OP_STOP       = 8'h00;
  localparam logic [7:0] UNARY_LIMIT   = 8'h12;
  localparam logic [7:0] TRAP_LO       = 8'h26;
  localparam logic [7:0] TRAP_UNARY_HI = 8'h27;
  localparam logic [7:0] TRAP_HI       = 8'h3F;

  typedef struct packed {
    logic [3:0] alu_fn;
    logic       reg_we;
    logic       nzvc_we;
  } dec_entry_t;

  // The two unary trap opcodes carry no operand specifier, like the opcodes below 0x12.
  function automatic logic is_unary_op(input logic [7:0] op);
    return (op < UNARY_LIMIT) || ((op >= TRAP_LO) && (op <= TRAP_UNARY_HI));
  endfunction

  function automatic logic is_trap_op(input logic [7:0] op);
    return (op >= TRAP_LO) && (op <= TRAP_HI);
  endfunction

endpackage

// File: rtl/pep9_control_sequencer_if.sv
// Byte-read memory handshake between the sequencer (master) and memory (slave).
interface pep9_control_sequencer_if;
  logic       mem_req;
  logic       mem_ack;
  logic [7:0] mem_rdata;

  modport master (output mem_req, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, output mem_ack, output mem_rdata);
endinterface

// File: rtl/pep9_is_decode.sv
// Combinational instruction-specifier decode: ALU function and write-enable flags.
// The trap-opcode flag port exists only with PEP9_TRAP_EN.
module pep9_is_decode
  import pep9_ctrl_pkg::*;
(
  input  logic [7:0] i_is,
  output dec_entry_t o_entry,
  output logic       o_unary
`ifdef PEP9_TRAP_EN
  ,
  output logic       o_trap
`endif
);

  always_comb begin
    // NOTE: default assignment first so an unlisted opcode can never infer a latch.
    o_entry = '{alu_fn: ALU_A, reg_we: 1'b0, nzvc_we: 1'b0};
    casez (i_is)
      8'h04:       o_entry = '{alu_fn: ALU_NZVC, reg_we: 1'b1, nzvc_we: 1'b0};  // MOVFLGA
      8'b0000_011?: o_entry = '{alu_fn: ALU_NOT, reg_we: 1'b1, nzvc_we: 1'b1};
      8'b0000_100?: o_entry = '{alu_fn: ALU_SUB, reg_we: 1'b1, nzvc_we: 1'b1};  // NEGr = 0 + ~r + 1
      8'b0000_101?: o_entry = '{alu_fn: ALU_ASL, reg_we: 1'b1, nzvc_we: 1'b1};
      8'b0000_110?: o_entry = '{alu_fn: ALU_ASR, reg_we: 1'b1, nzvc_we: 1'b1};
      8'b0110_????: o_entry = '{alu_fn: ALU_ADD, reg_we: 1'b1, nzvc_we: 1'b1};
      8'b0111_????: o_entry = '{alu_fn: ALU_SUB, reg_we: 1'b1, nzvc_we: 1'b1};
      8'b1010_????: o_entry = '{alu_fn: ALU_SUB, reg_we: 1'b0, nzvc_we: 1'b1};  // CPWr: flags only
      8'b1100_????: o_entry = '{alu_fn: ALU_A,   reg_we: 1'b1, nzvc_we: 1'b1};
      default:      o_entry = '{alu_fn: ALU_A,   reg_we: 1'b0, nzvc_we: 1'b0};
    endcase
  end

  assign o_unary = is_unary_op(i_is);
`ifdef PEP9_TRAP_EN
  assign o_trap  = is_trap_op(i_is);
`endif

endmodule

// File: rtl/pep9_control_sequencer.sv
// Pep9 fetch/decode/execute control sequencer with registered outputs.
// Optional trap handling for opcodes 0x26-0x3F is enabled by defining PEP9_TRAP_EN.
module pep9_control_sequencer
  import pep9_ctrl_pkg::*;
(
  input  logic                            Sysclk,
  input  logic                            resetbar,
  input  logic                            run,
  pep9_control_sequencer_if.master        mem,
  output logic [7:0]                      InstructionSpecifier,
  output logic [15:0]                     opspec,
  output logic [3:0]                      alu_fn,
  output logic                            pc_inc,
  output logic                            reg_we,
  output logic                            nzvc_we,
  output logic                            halted,
  output logic                            trap
);

  state_t     r_state;
  logic [7:0] r_is;
  logic [15:0] r_opspec;
  logic [3:0] r_alu_fn;
  logic       r_mem_req, r_pc_inc, r_reg_we, r_nzvc_we, r_halted;
  dec_entry_t w_entry;
  logic       w_unary;
`ifdef PEP9_TRAP_EN
  logic       r_trap;
  logic       w_trap_op;
`endif

  pep9_is_decode u_decode (
    .i_is    (r_is),
    .o_entry (w_entry),
`ifdef PEP9_TRAP_EN
    .o_unary (w_unary),
    .o_trap  (w_trap_op)
`else
    .o_unary (w_unary)
`endif
  );

  always_ff @(posedge Sysclk or negedge resetbar) begin
    if (!resetbar) begin
      r_state   <= IDLE;
      r_is      <= 8'h00;
      r_opspec  <= 16'h0000;
      r_alu_fn  <= ALU_A;
      r_mem_req <= 1'b0;
      r_pc_inc  <= 1'b0;
      r_reg_we  <= 1'b0;
      r_nzvc_we <= 1'b0;
      r_halted  <= 1'b0;
`ifdef PEP9_TRAP_EN
      r_trap    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking defaults here make every pulse output exactly one cycle wide.
      r_pc_inc  <= 1'b0;
      r_reg_we  <= 1'b0;
      r_nzvc_we <= 1'b0;
      r_alu_fn  <= ALU_A;
`ifdef PEP9_TRAP_EN
      r_trap    <= 1'b0;
`endif
      case (r_state)
        IDLE: if (run) begin
          r_state   <= FETCH_IS;
          r_mem_req <= 1'b1;
        end
        FETCH_IS: if (mem.mem_ack) begin
          r_is      <= mem.mem_rdata;
          r_pc_inc  <= 1'b1;
          r_mem_req <= 1'b0;
          r_state   <= DECODE;
        end
        DECODE: begin
          if (r_is == OP_STOP) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end
`ifdef PEP9_TRAP_EN
          else if (w_trap_op && w_unary) begin
            r_state <= TRAP;
            r_trap  <= 1'b1;
          end
`endif
          else if (w_unary) begin
            r_state  <= EXEC;
            r_alu_fn <= w_entry.alu_fn;
          end else begin
            r_state   <= FETCH_OP_HI;
            r_mem_req <= 1'b1;
          end
        end
        // The request stays high from the high-byte into the low-byte fetch.
        FETCH_OP_HI: if (mem.mem_ack) begin
          r_opspec[15:8] <= mem.mem_rdata;
          r_pc_inc       <= 1'b1;
          r_state        <= FETCH_OP_LO;
        end
        FETCH_OP_LO: if (mem.mem_ack) begin
          r_opspec[7:0] <= mem.mem_rdata;
          r_pc_inc      <= 1'b1;
          r_mem_req     <= 1'b0;
`ifdef PEP9_TRAP_EN
          if (w_trap_op) begin
            r_state <= TRAP;
            r_trap  <= 1'b1;
          end else
`endif
          begin
            r_state  <= EXEC;
            r_alu_fn <= w_entry.alu_fn;
          end
        end
        EXEC: begin
          r_state   <= WB;
          r_reg_we  <= w_entry.reg_we;
          r_nzvc_we <= w_entry.nzvc_we;
        end
        WB: begin
          r_state   <= run ? FETCH_IS : IDLE;
          r_mem_req <= run;
        end
`ifdef PEP9_TRAP_EN
        TRAP: begin
          r_state   <= FETCH_IS;
          r_mem_req <= 1'b1;
        end
`endif
        HALT:    r_state <= HALT;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem.mem_req          = r_mem_req;
  assign InstructionSpecifier = r_is;
  assign opspec               = r_opspec;
  assign alu_fn               = r_alu_fn;
  assign pc_inc               = r_pc_inc;
  assign reg_we               = r_reg_we;
  assign nzvc_we              = r_nzvc_we;
  assign halted               = r_halted;
`ifdef PEP9_TRAP_EN
  assign trap                 = r_trap;
`else
  assign trap                 = 1'b0;
`endif

endmodule

// File: tb/tb_pep9_control_sequencer.sv
// Directed self-checking bench for pep9_control_sequencer with a byte-memory responder
// of programmable ack delay; trap expectations follow PEP9_TRAP_EN.
module tb_pep9_control_sequencer;

`ifdef PEP9_TRAP_EN
  localparam int TRAP_BUILD = 1;
`else
  localparam int TRAP_BUILD = 0;
`endif

  logic        Sysclk = 1'b0;
  logic        resetbar;
  logic        run;
  logic [7:0]  InstructionSpecifier;
  logic [15:0] opspec;
  logic [3:0]  alu_fn;
  logic        pc_inc, reg_we, nzvc_we, halted, trap;

  pep9_control_sequencer_if mif();

  pep9_control_sequencer dut (
    .Sysclk               (Sysclk),
    .resetbar             (resetbar),
    .run                  (run),
    .mem                  (mif),
    .InstructionSpecifier (InstructionSpecifier),
    .opspec               (opspec),
    .alu_fn               (alu_fn),
    .pc_inc               (pc_inc),
    .reg_we               (reg_we),
    .nzvc_we              (nzvc_we),
    .halted               (halted),
    .trap                 (trap)
  );

  always #5 Sysclk = ~Sysclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after ack_delay waiting cycles, rdata valid with ack.
  logic [7:0] mem_bytes [8];
  int  mem_idx   = 0;
  int  wait_cnt  = 0;
  int  ack_delay = 0;
  bit  mem_en    = 0;
  bit  force_ack = 0;

  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 8'h00;
    forever begin
      @(posedge Sysclk); #1;
      if (mif.mem_ack && mem_en) mem_idx++;
      mif.mem_ack = 1'b0;
      if (force_ack) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 8'hFF;
      end else if (mem_en && mif.mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = mem_bytes[mem_idx % 8];
          wait_cnt      = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Output monitor: pulse counts, timing marks and over-long pulse detection.
  int cyc = 0, pc_cnt, reg_cnt, nzvc_cnt, trap_cnt, alu_cnt, alu_last, alu_cyc, reg_cyc;
  int req_rise, long_pulse;
  bit prev_req = 0, prev_pc = 0, prev_reg = 0, prev_nzvc = 0, prev_trap = 0;

  task automatic clear_mon();
    pc_cnt = 0; reg_cnt = 0; nzvc_cnt = 0; trap_cnt = 0; alu_cnt = 0;
    alu_last = 0; alu_cyc = 0; reg_cyc = 0; req_rise = -1; long_pulse = 0;
  endtask

  initial begin
    clear_mon();
    forever begin
      @(posedge Sysclk); #1;
      cyc++;
      if (pc_inc) pc_cnt++;
      if (reg_we) begin reg_cnt++; reg_cyc = cyc; end
      if (nzvc_we) nzvc_cnt++;
      if (trap) trap_cnt++;
      if (alu_fn != 4'd0) begin alu_cnt++; alu_last = int'(alu_fn); alu_cyc = cyc; end
      if (mif.mem_req && !prev_req && req_rise < 0) req_rise = cyc;
      if ((pc_inc && prev_pc) || (reg_we && prev_reg) || (nzvc_we && prev_nzvc) || (trap && prev_trap))
        long_pulse++;
      prev_req = mif.mem_req; prev_pc = pc_inc; prev_reg = reg_we;
      prev_nzvc = nzvc_we; prev_trap = trap;
    end
  end

  task automatic do_reset();
    resetbar = 1'b0; run = 1'b0; mem_en = 1'b0; force_ack = 1'b0;
    repeat (2) @(negedge Sysclk);
    mem_idx = 0; wait_cnt = 0;
    resetbar = 1'b1;
    clear_mon();
  endtask

  // Load up to four bytes, raise run for one cycle; the instruction then finishes to IDLE.
  task automatic start(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input int delay);
    mem_bytes[0] = b0; mem_bytes[1] = b1; mem_bytes[2] = b2; mem_bytes[3] = b3;
    for (int i = 4; i < 8; i++) mem_bytes[i] = 8'h00;
    mem_idx = 0; wait_cnt = 0; ack_delay = delay; mem_en = 1'b1;
    run = 1'b1;
    @(negedge Sysclk);
    run = 1'b0;
  endtask

  initial begin
    resetbar = 1'b0; run = 1'b0;
    @(negedge Sysclk);
    check("rst_is", InstructionSpecifier, 8'h00);
    check("rst_opspec", opspec, 16'h0000);
    check("rst_alu_fn", alu_fn, 4'd0);
    check("rst_mem_req", mif.mem_req, 1'b0);
    check("rst_pulses", {pc_inc, reg_we, nzvc_we, halted, trap}, 5'b0);

    // NEGA: unary, 4 cycles from request to write-back.
    do_reset();
    start(8'h08, 8'h00, 8'h00, 8'h00, 0);
    repeat (8) @(negedge Sysclk);
    check("nega_is", InstructionSpecifier, 8'h08);
    check("nega_pc_inc", pc_cnt, 1);
    check("nega_alu_cycles", alu_cnt, 1);
    check("nega_alu_fn", alu_last, 3);
    check("nega_reg_we", reg_cnt, 1);
    check("nega_nzvc_we", nzvc_cnt, 1);
    check("nega_wb_after_exec", reg_cyc - alu_cyc, 1);
    check("nega_latency", reg_cyc - req_rise + 1, 4);
    check("nega_back_to_idle", mif.mem_req, 1'b0);

    // ADDA immediate: non-unary, 6 cycles with single-cycle acks.
    do_reset();
    start(8'h60, 8'h00, 8'h05, 8'h00, 0);
    repeat (10) @(negedge Sysclk);
    check("adda_opspec", opspec, 16'h0005);
    check("adda_alu_fn", alu_last, 1);
    check("adda_latency", reg_cyc - req_rise + 1, 6);
    check("adda_pc_inc", pc_cnt, 3);

    // LDWA with three-cycle ack delay: request must stay high while waiting.
    do_reset();
    mem_bytes[0] = 8'hC0; mem_bytes[1] = 8'h12; mem_bytes[2] = 8'h34;
    mem_idx = 0; wait_cnt = 0; ack_delay = 3; mem_en = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Sysclk);
      run = 1'b0;
      check("ldw_req_held", mif.mem_req, 1'b1);
    end
    check("ldw_no_early_inc", pc_cnt, 0);
    repeat (25) @(negedge Sysclk);
    check("ldw_is", InstructionSpecifier, 8'hC0);
    check("ldw_opspec", opspec, 16'h1234);
    check("ldw_pc_inc", pc_cnt, 3);
    check("ldw_alu_zero", alu_cnt, 0);
    check("ldw_reg_we", reg_cnt, 1);
    check("ldw_nzvc_we", nzvc_cnt, 1);
    check("ldw_pulse_width", long_pulse, 0);

    // STOP: halts, ignores run, leaves only through reset.
    do_reset();
    start(8'h00, 8'h00, 8'h00, 8'h00, 0);
    repeat (4) @(negedge Sysclk);
    check("stop_halted", halted, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run = ~run;
      @(negedge Sysclk);
    end
    run = 1'b0;
    check("stop_still_halted", halted, 1'b1);
    check("stop_no_fetch", {mif.mem_req, 4'(pc_cnt)}, {1'b0, 4'd1});
    resetbar = 1'b0; mem_en = 1'b0;
    #1;
    check("stop_async_clear", halted, 1'b0);
    @(negedge Sysclk);
    resetbar = 1'b1;
    repeat (2) @(negedge Sysclk);
    check("stop_idle_no_req", mif.mem_req, 1'b0);
    run = 1'b1;
    @(negedge Sysclk);
    run = 1'b0;
    check("stop_restart_fetch", {halted, mif.mem_req}, 2'b01);

    // Trap-range opcodes: trap pulse when enabled, otherwise NOPs.
    do_reset();
    start(8'h26, 8'h00, 8'h00, 8'h00, 0);
    repeat (10) @(negedge Sysclk);
    check("op26_trap", trap_cnt, TRAP_BUILD);
    check("op26_no_writes", {4'(reg_cnt), 4'(nzvc_cnt), 4'(alu_cnt)}, 12'h000);
    check("op26_halt_after", halted, TRAP_BUILD[0]);

    do_reset();
    start(8'h30, 8'hAA, 8'hBB, 8'h00, 0);
    repeat (12) @(negedge Sysclk);
    check("op30_opspec", opspec, 16'hAABB);
    check("op30_trap", trap_cnt, TRAP_BUILD);
    check("op30_pc_inc", pc_cnt, 3 + TRAP_BUILD);
    check("op30_no_writes", {4'(reg_cnt), 4'(nzvc_cnt)}, 8'h00);

    // Reset during FETCH_OP_LO, then a spurious ack in IDLE.
    do_reset();
    start(8'hC0, 8'h12, 8'h34, 8'h00, 3);
    for (int i = 0; i < 40 && pc_cnt < 2; i++) @(negedge Sysclk);
    check("abort_reached_op_lo", {mif.mem_req, opspec}, {1'b1, 16'h1200});
    resetbar = 1'b0; mem_en = 1'b0;
    #1;
    check("abort_outputs_zero",
          {mif.mem_req, InstructionSpecifier, opspec, alu_fn, pc_inc, reg_we, nzvc_we, halted, trap}, 34'd0);
    @(negedge Sysclk);
    resetbar = 1'b1;
    clear_mon();
    repeat (5) @(negedge Sysclk);
    check("abort_no_pulses", {4'(pc_cnt), 4'(reg_cnt), 4'(nzvc_cnt), mif.mem_req}, 13'd0);
    force_ack = 1'b1;
    repeat (3) @(negedge Sysclk);
    force_ack = 1'b0;
    check("spurious_ack_ignored", {InstructionSpecifier, 4'(pc_cnt), mif.mem_req}, 13'd0);
    repeat (2) @(negedge Sysclk);
    start(8'h08, 8'h00, 8'h00, 8'h00, 0);
    repeat (8) @(negedge Sysclk);
    check("after_spurious_nega", {InstructionSpecifier, 4'(alu_last)}, {8'h08, 4'd3});
    check("all_pulse_width", long_pulse, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
